sequence_control_unit: RTL and testbench

SEQUENCE_CONTROL_UNIT -- requirements
Module: sequence_control_unit

---
 rtl/sequence_control_unit_pkg.sv | 58 +++++
 rtl/sequence_control_unit_sequence_counter.sv | 40 ++++
 rtl/sequence_control_unit.sv | 144 ++++++++++++++
 tb/tb_sequence_control_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sequence_control_unit_pkg.sv
// Shared types and encodings for the sequence control unit and its datapath:
// state enum, opcodes, FunSel/ALU/OutSel codes and register-select helpers.
package sequence_control_unit_pkg;

  typedef enum logic [2:0] {
    ST_CLR  = 3'd0,
    ST_T0   = 3'd1,
    ST_T1   = 3'd2,
    ST_T2   = 3'd3,
    ST_T3   = 3'd4,
    ST_HALT = 3'd5
  } state_e;

  localparam logic [5:0] OP_BRA = 6'h00;
  localparam logic [5:0] OP_BEQ = 6'h01;
  localparam logic [5:0] OP_LDI = 6'h02;
  localparam logic [5:0] OP_LD  = 6'h03;
  localparam logic [5:0] OP_ST  = 6'h04;
  localparam logic [5:0] OP_ADD = 6'h05;
  localparam logic [5:0] OP_SUB = 6'h06;
  localparam logic [5:0] OP_AND = 6'h07;
  localparam logic [5:0] OP_ORR = 6'h08;
  localparam logic [5:0] OP_HLT = 6'h3F;

  localparam logic [2:0] FUNSEL_CLEAR = 3'b011;
  localparam logic [2:0] FUNSEL_LOAD  = 3'b010;
  localparam logic [2:0] FUNSEL_INC   = 3'b001;

  localparam logic [4:0] ALU_PASSA = 5'b10000;
  localparam logic [4:0] ALU_ADD   = 5'b10100;
  localparam logic [4:0] ALU_SUB   = 5'b10110;
  localparam logic [4:0] ALU_AND   = 5'b10111;
  localparam logic [4:0] ALU_ORR   = 5'b11000;

  localparam logic [1:0] OUTSEL_PC = 2'b00;
  localparam logic [1:0] OUTSEL_AR = 2'b10;
  localparam logic [1:0] OUTSEL_SP = 2'b11;

  // ARF_RegSel bit order is {PC, AR, SP}.
  localparam logic [2:0] ARF_SEL_PC = 3'b100;
  localparam logic [2:0] ARF_SEL_AR = 3'b010;
  localparam logic [2:0] ARF_SEL_SP = 3'b001;

  // Register field 0..3 names R1..R4, which sit at RegSel bit3..bit0.
  function automatic logic [3:0] onehot(input logic [1:0] x);
    return 4'b1000 >> x;
  endfunction

  function automatic logic [4:0] alu_op(input logic [5:0] opcode);
    case (opcode)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      default: return ALU_ORR;
    endcase
  endfunction

endpackage

// File: rtl/sequence_control_unit_sequence_counter.sv
// State register and next-state logic: CLR -> T0 -> T1 -> T2 [-> T3] -> T0,
// with HLT parking in HALT until reset.
module sequence_counter
  import sequence_control_unit_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [5:0] opcode_i,
  output state_e     state_o
);

  state_e state_q, state_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_CLR;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLR: state_d = ST_T0;
      ST_T0:  state_d = ST_T1;
      ST_T1:  state_d = ST_T2;
      ST_T2: begin
        case (opcode_i)
          OP_LD, OP_ST: state_d = ST_T3;
          OP_HLT:       state_d = ST_HALT;
          default:      state_d = ST_T0;
        endcase
      end
      ST_T3:   state_d = ST_T0;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_CLR;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/sequence_control_unit.sv
// Hardwired controller: Moore decode of the sequence state and IROut into the
// datapath control word. Dbg_State exposes the current state.
module sequence_control_unit
  import sequence_control_unit_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic [3:0]  FlagsOut,
  output logic [2:0]  RF_FunSel,
  output logic [2:0]  ARF_FunSel,
  output logic [4:0]  ALU_FunSel,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  RF_ScrSel,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [2:0]  ARF_RegSel,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic [0:0]  MuxCSel,
  output logic        ALU_WF,
  output logic        IR_LH,
  output logic        IR_Write,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic        Halted,
  output state_e      Dbg_State
);

  state_e     state;
  logic [5:0] opcode;
  logic [1:0] r_fld, dst_fld, s1_fld, s2_fld;
  logic       flag_z;
  logic [2:0] unused_flags;

  assign opcode       = IROut[15:10];
  assign r_fld        = IROut[9:8];
  assign dst_fld      = IROut[5:4];
  assign s1_fld       = IROut[3:2];
  assign s2_fld       = IROut[1:0];
  assign flag_z       = FlagsOut[3];
  assign unused_flags = FlagsOut[2:0];

  sequence_counter u_seq (
    .clk_i    (Clock),
    .rst_ni   (Reset),
    .opcode_i (opcode),
    .state_o  (state)
  );

  assign Dbg_State = state;

  // IMM reaches the datapath through MuxA/MuxB input 11, so only selects are driven here.
  always_comb begin
    RF_FunSel   = '0;
    ARF_FunSel  = '0;
    ALU_FunSel  = '0;
    RF_OutASel  = '0;
    RF_OutBSel  = '0;
    RF_RegSel   = '0;
    RF_ScrSel   = '0;
    ARF_OutCSel = '0;
    ARF_OutDSel = OUTSEL_PC;
    ARF_RegSel  = '0;
    MuxASel     = '0;
    MuxBSel     = '0;
    MuxCSel     = '0;
    ALU_WF      = 1'b0;
    IR_LH       = 1'b0;
    IR_Write    = 1'b0;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    Halted      = 1'b0;
    if (Reset) begin
      case (state)
        ST_CLR: begin
          RF_RegSel  = 4'b1111;
          RF_ScrSel  = 4'b1111;
          ARF_RegSel = ARF_SEL_PC | ARF_SEL_AR | ARF_SEL_SP;
          RF_FunSel  = FUNSEL_CLEAR;
          ARF_FunSel = FUNSEL_CLEAR;
        end
        ST_T0, ST_T1: begin
          ARF_OutDSel = OUTSEL_PC;
          Mem_CS      = 1'b0;
          IR_Write    = 1'b1;
          IR_LH       = (state == ST_T1);
          ARF_RegSel  = ARF_SEL_PC;
          ARF_FunSel  = FUNSEL_INC;
        end
        ST_T2: begin
          case (opcode)
            OP_BRA, OP_BEQ: begin
              if (opcode == OP_BRA || flag_z) begin
                MuxBSel    = 2'b11;
                ARF_RegSel = ARF_SEL_PC;
                ARF_FunSel = FUNSEL_LOAD;
              end
            end
            OP_LDI: begin
              MuxASel   = 2'b11;
              RF_RegSel = onehot(r_fld);
              RF_FunSel = FUNSEL_LOAD;
            end
            OP_LD, OP_ST: begin
              MuxBSel    = 2'b11;
              ARF_RegSel = ARF_SEL_AR;
              ARF_FunSel = FUNSEL_LOAD;
            end
            OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
              RF_OutASel = {1'b0, s1_fld};
              RF_OutBSel = {1'b0, s2_fld};
              ALU_FunSel = alu_op(opcode);
              ALU_WF     = 1'b1;
              MuxASel    = 2'b00;
              RF_RegSel  = onehot(dst_fld);
              RF_FunSel  = FUNSEL_LOAD;
            end
            default: ;
          endcase
        end
        ST_T3: begin
          ARF_OutDSel = OUTSEL_AR;
          Mem_CS      = 1'b0;
          if (opcode == OP_ST) begin
            RF_OutASel = {1'b0, r_fld};
            ALU_FunSel = ALU_PASSA;
            MuxCSel    = 1'b0;
            Mem_WR     = 1'b1;
          end else begin
            MuxASel   = 2'b10;
            RF_RegSel = onehot(r_fld);
            RF_FunSel = FUNSEL_LOAD;
          end
        end
        ST_HALT: Halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_control_unit.sv
// Directed, table-driven bench for sequence_control_unit: each record gives an
// instruction, flags and the expected control word in T2 (and T3 when used).
module tb_sequence_control_unit;
  import sequence_control_unit_pkg::*;

  typedef struct packed {
    logic [2:0] rf_fun;
    logic [2:0] arf_fun;
    logic [4:0] alu_fun;
    logic [2:0] outa;
    logic [2:0] outb;
    logic [3:0] rf_reg;
    logic [3:0] rf_scr;
    logic [1:0] outc;
    logic [1:0] outd;
    logic [2:0] arf_reg;
    logic [1:0] mux_a;
    logic [1:0] mux_b;
    logic       mux_c;
    logic       alu_wf;
    logic       ir_lh;
    logic       ir_write;
    logic       mem_wr;
    logic       mem_cs;
    logic       halted;
  } ctrl_t;

  typedef struct {
    string       name;
    logic [15:0] ir;
    logic [3:0]  flags;
    ctrl_t       exp_t2;
    logic        has_t3;
    ctrl_t       exp_t3;
  } vec_t;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] IROut = 16'h0000;
  logic [3:0]  FlagsOut = 4'b0000;
  logic [2:0]  RF_FunSel, ARF_FunSel, RF_OutASel, RF_OutBSel, ARF_RegSel;
  logic [4:0]  ALU_FunSel;
  logic [3:0]  RF_RegSel, RF_ScrSel;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel, MuxASel, MuxBSel;
  logic [0:0]  MuxCSel;
  logic        ALU_WF, IR_LH, IR_Write, Mem_WR, Mem_CS, Halted;
  state_e      Dbg_State;
  ctrl_t       act;

  int n_checks = 0;
  int n_pass   = 0;
  vec_t vecs[$];

  sequence_control_unit dut (
    .Clock(Clock), .Reset(Reset), .IROut(IROut), .FlagsOut(FlagsOut),
    .RF_FunSel(RF_FunSel), .ARF_FunSel(ARF_FunSel), .ALU_FunSel(ALU_FunSel),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_RegSel(RF_RegSel),
    .RF_ScrSel(RF_ScrSel), .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
    .ARF_RegSel(ARF_RegSel), .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
    .ALU_WF(ALU_WF), .IR_LH(IR_LH), .IR_Write(IR_Write), .Mem_WR(Mem_WR),
    .Mem_CS(Mem_CS), .Halted(Halted), .Dbg_State(Dbg_State)
  );

  assign act = {RF_FunSel, ARF_FunSel, ALU_FunSel, RF_OutASel, RF_OutBSel,
                RF_RegSel, RF_ScrSel, ARF_OutCSel, ARF_OutDSel, ARF_RegSel,
                MuxASel, MuxBSel, MuxCSel, ALU_WF, IR_LH, IR_Write, Mem_WR,
                Mem_CS, Halted};

  always #5 Clock = ~Clock;

  function automatic ctrl_t idle();
    ctrl_t c;
    c = '0;
    c.mem_cs = 1'b1;
    return c;
  endfunction

  task automatic check_ctrl(input string name, input ctrl_t exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: control word got %h expected %h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic check_state(input string name, input state_e exp);
    n_checks++;
    if (Dbg_State !== exp)
      $display("FAIL %s: state got %0d expected %0d", name, Dbg_State, exp);
    else
      n_pass++;
  endtask

  task automatic add_vec(input string name, input logic [15:0] ir, input logic [3:0] flags,
                         input ctrl_t t2, input logic has_t3, input ctrl_t t3);
    vec_t v;
    v.name = name; v.ir = ir; v.flags = flags;
    v.exp_t2 = t2; v.has_t3 = has_t3; v.exp_t3 = t3;
    vecs.push_back(v);
  endtask

  // Entered at a negedge while in T0; returns at the negedge of the following T0,
  // or of T3 when stop_in_t3 is set.
  task automatic run_vec(input vec_t v, input ctrl_t t1_exp, input logic stop_in_t3);
    IROut    = v.ir;
    FlagsOut = v.flags;
    @(negedge Clock);
    check_state({v.name, " T1 state"}, ST_T1);
    check_ctrl({v.name, " T1"}, t1_exp);
    @(negedge Clock);
    check_state({v.name, " T2 state"}, ST_T2);
    check_ctrl({v.name, " T2"}, v.exp_t2);
    if (v.has_t3) begin
      @(negedge Clock);
      check_state({v.name, " T3 state"}, ST_T3);
      check_ctrl({v.name, " T3"}, v.exp_t3);
    end
    if (!stop_in_t3) begin
      @(negedge Clock);
      check_state({v.name, " back to T0"}, ST_T0);
    end
  endtask

  initial begin
    ctrl_t c, c3, clr_exp, t0_exp, t1_exp, t2_mem, halt_exp;

    clr_exp = idle();
    clr_exp.rf_reg = 4'b1111; clr_exp.rf_scr = 4'b1111; clr_exp.arf_reg = 3'b111;
    clr_exp.rf_fun = 3'b011;  clr_exp.arf_fun = 3'b011;
    t0_exp = idle();
    t0_exp.outd = 2'b00; t0_exp.mem_cs = 1'b0; t0_exp.ir_write = 1'b1;
    t0_exp.arf_reg = 3'b100; t0_exp.arf_fun = 3'b001;
    t1_exp = t0_exp; t1_exp.ir_lh = 1'b1;
    t2_mem = idle();
    t2_mem.mux_b = 2'b11; t2_mem.arf_reg = 3'b010; t2_mem.arf_fun = 3'b010;
    halt_exp = idle(); halt_exp.halted = 1'b1;

    c = idle(); c.mux_a = 2'b11; c.rf_reg = 4'b0100; c.rf_fun = 3'b010;
    add_vec("ldi_r2", 16'h095A, 4'b0000, c, 1'b0, idle());
    c = idle(); c.mux_a = 2'b11; c.rf_reg = 4'b0010; c.rf_fun = 3'b010;
    add_vec("ldi_r3", 16'h0A5A, 4'b0000, c, 1'b0, idle());
    add_vec("beq_not_taken", 16'h0412, 4'b0000, idle(), 1'b0, idle());
    add_vec("beq_other_flags", 16'h0412, 4'b0111, idle(), 1'b0, idle());
    c = idle(); c.mux_b = 2'b11; c.arf_reg = 3'b100; c.arf_fun = 3'b010;
    add_vec("beq_taken", 16'h0412, 4'b1000, c, 1'b0, idle());
    add_vec("bra", 16'h0033, 4'b0000, c, 1'b0, idle());
    c3 = idle(); c3.outa = 3'b000; c3.alu_fun = 5'b10000; c3.outd = 2'b10;
    c3.mem_cs = 1'b0; c3.mem_wr = 1'b1;
    add_vec("st_r1", 16'h1020, 4'b0000, t2_mem, 1'b1, c3);
    c3.outa = 3'b011;
    add_vec("st_r4", 16'h1320, 4'b0000, t2_mem, 1'b1, c3);
    c3 = idle(); c3.outd = 2'b10; c3.mem_cs = 1'b0; c3.mux_a = 2'b10;
    c3.rf_reg = 4'b0010; c3.rf_fun = 3'b010;
    add_vec("ld_r3", 16'h0E40, 4'b0000, t2_mem, 1'b1, c3);
    c = idle(); c.outa = 3'b010; c.outb = 3'b011; c.alu_fun = 5'b10100; c.alu_wf = 1'b1;
    c.rf_reg = 4'b0100; c.rf_fun = 3'b010;
    add_vec("add", 16'h141B, 4'b0000, c, 1'b0, idle());
    c = idle(); c.outa = 3'b001; c.outb = 3'b010; c.alu_fun = 5'b10110; c.alu_wf = 1'b1;
    c.rf_reg = 4'b0001; c.rf_fun = 3'b010;
    add_vec("sub", 16'h1836, 4'b0000, c, 1'b0, idle());
    c = idle(); c.outa = 3'b011; c.outb = 3'b001; c.alu_fun = 5'b10111; c.alu_wf = 1'b1;
    c.rf_reg = 4'b1000; c.rf_fun = 3'b010;
    add_vec("and", 16'h1C0D, 4'b0000, c, 1'b0, idle());
    c = idle(); c.outa = 3'b001; c.outb = 3'b000; c.alu_fun = 5'b11000; c.alu_wf = 1'b1;
    c.rf_reg = 4'b0010; c.rf_fun = 3'b010;
    add_vec("orr", 16'h2024, 4'b0000, c, 1'b0, idle());
    add_vec("nop_09", 16'h24FF, 4'b1111, idle(), 1'b0, idle());
    add_vec("nop_3e", 16'hF800, 4'b0000, idle(), 1'b0, idle());

    // Reset held: idle outputs even though the state register is CLR.
    repeat (3) @(negedge Clock);
    check_state("reset state", ST_CLR);
    check_ctrl("reset outputs idle", idle());
    Reset = 1'b1;
    #1;
    check_ctrl("clr decode", clr_exp);
    @(negedge Clock);
    check_state("first T0 state", ST_T0);
    check_ctrl("first T0", t0_exp);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], t1_exp, 1'b0);

    // Reset asserted mid-LD T3 must drop to CLR at once.
    run_vec(vecs[8], t1_exp, 1'b1);
    #2 Reset = 1'b0;
    #1;
    check_state("reset in T3 state", ST_CLR);
    check_ctrl("reset in T3 outputs", idle());
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    check_ctrl("clr after T3 reset", clr_exp);
    @(negedge Clock);
    check_state("T0 after T3 reset", ST_T0);
    check_ctrl("T0 after T3 reset out", t0_exp);

    // HLT parks in HALT with only Halted raised; reset is the only way out.
    IROut = 16'hFC00;
    @(negedge Clock);
    @(negedge Clock);
    check_state("hlt T2 state", ST_T2);
    check_ctrl("hlt T2", idle());
    for (int k = 0; k < 10; k++) begin
      @(negedge Clock);
      check_state($sformatf("halt state %0d", k), ST_HALT);
      check_ctrl($sformatf("halt out %0d", k), halt_exp);
    end
    #2 Reset = 1'b0;
    #1;
    check_state("reset in halt state", ST_CLR);
    check_ctrl("reset in halt outputs", idle());
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    check_state("T0 after halt reset", ST_T0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
